// File: rtl/axi4_st_pkg.sv
// Shared constants, pointer-width helper and output-register layout for the
// AXI4-Stream transmitter.
package axi4_st_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_LEN_W  = 8;

  // One extra MSB beyond the address bits tells full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic [DEF_DATA_W-1:0] tdata;
    logic                  tlast;
  } out_reg_t;

endpackage

// File: rtl/axi4_st_fifo_mem.sv
// Register-array storage for the transmit FIFO: one synchronous write port,
// one combinational read port.
module axi4_st_fifo_mem
  import axi4_st_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi4_st_tx.sv
// AXI4-Stream transmitter: write-strobe input, DEPTH-entry FIFO, registered
// master port with TLAST generated from a per-packet length.
module axi4_st_tx
  import axi4_st_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                     in_clk,
  input  logic                     in_rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_wr,
  input  logic [LEN_W-1:0]         in_pkt_len,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  input  logic                     in_clr_ovf,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  input  logic                     m_tready
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]     r_wptr, r_rptr, r_count;
  logic              r_full, r_ovf;
  logic [DATA_W-1:0] r_tdata;
  logic              r_tvalid, r_tlast;
  logic [LEN_W-1:0]  r_beat, r_len;

  logic              w_empty, w_push, w_drop, w_load, w_last;
  logic [PW-1:0]     w_wptr_nxt, w_rptr_nxt;
  logic [DATA_W-1:0] w_rdata;
  logic [LEN_W-1:0]  w_len_eff, w_len_cur;

  // Handshake: a beat transfers on a rising edge where m_tvalid=1 and
  // m_tready=1. m_tvalid is a register and never looks at m_tready
  // combinationally; the register reloads only when empty or being taken.
  assign w_empty = (r_wptr == r_rptr);
  assign w_push  = in_wr & ~r_full;
  assign w_drop  = in_wr & r_full;
  assign w_load  = ~w_empty & (~r_tvalid | m_tready);

  assign w_wptr_nxt = r_wptr + PW'(w_push);
  assign w_rptr_nxt = r_rptr + PW'(w_load);

  // A zero length behaves as single-beat packets.
  assign w_len_eff = (in_pkt_len == '0) ? LEN_W'(1) : in_pkt_len;
  assign w_len_cur = (r_beat == '0) ? w_len_eff : r_len;
  assign w_last    = (r_beat == w_len_cur - LEN_W'(1));

  axi4_st_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .i_clk   (in_clk),
    .i_we    (w_push),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (in_data),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_beat   <= '0;
      r_len    <= '0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      // Flags are registered from the next-state pointers.
      r_count <= w_wptr_nxt - w_rptr_nxt;
      r_full  <= ((w_wptr_nxt ^ w_rptr_nxt) == {1'b1, {AW{1'b0}}});

      if (w_drop)          r_ovf <= 1'b1;
      else if (in_clr_ovf) r_ovf <= 1'b0;

      if (w_load) begin
        r_tdata  <= w_rdata;
        r_tvalid <= 1'b1;
        r_tlast  <= w_last;
        if (r_beat == '0) r_len <= w_len_eff;
        r_beat   <= w_last ? '0 : r_beat + LEN_W'(1);
      end else if (r_tvalid && m_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign o_full     = r_full;
  assign o_count    = r_count;
  assign o_overflow = r_ovf;
  assign m_tdata    = r_tdata;
  assign m_tvalid   = r_tvalid;
  assign m_tlast    = r_tlast;

endmodule

// File: tb/tb_axi4_st_tx.sv
// Directed and randomised-backpressure bench for axi4_st_tx with a queue-level
// reference model checked every cycle plus literal expectations per scenario.
module tb_axi4_st_tx;
  import axi4_st_pkg::*;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int LEN_W  = 8;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              in_clk = 1'b0;
  logic              in_rst_n = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_wr = 1'b0;
  logic [LEN_W-1:0]  in_pkt_len = '0;
  logic              o_full;
  logic [CW-1:0]     o_count;
  logic              o_overflow;
  logic              in_clr_ovf = 1'b0;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready = 1'b0;

  int checks = 0;
  int errors = 0;

  axi4_st_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .in_clk     (in_clk),
    .in_rst_n   (in_rst_n),
    .in_data    (in_data),
    .in_wr      (in_wr),
    .in_pkt_len (in_pkt_len),
    .o_full     (o_full),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .in_clr_ovf (in_clr_ovf),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready)
  );

  // ---------------- clock ----------------
  always #5 in_clk = ~in_clk;

  // ---------------- reference model ----------------
  // Pending words, the word on the bus, and position inside the current packet.
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] exp_q[$];
  bit                mv = 0;
  logic [DATA_W-1:0] md = '0;
  bit                ml = 0;
  int                mbeat = 0;
  int                mlen = 1;
  bit                movf = 0;
  bit                was_full;

  always @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      mq.delete();
      exp_q.delete();
      mv = 0; md = '0; ml = 0; mbeat = 0; mlen = 1; movf = 0;
    end else begin
      was_full = (mq.size() == DEPTH);
      if (mq.size() > 0 && (!mv || m_tready)) begin
        md = mq.pop_front();
        mv = 1;
        if (mbeat == 0) mlen = (in_pkt_len == 0) ? 1 : int'(in_pkt_len);
        ml = (mbeat == mlen - 1);
        mbeat = ml ? 0 : mbeat + 1;
      end else if (mv && m_tready) begin
        mv = 0;
      end
      if (in_wr && !was_full) begin
        mq.push_back(in_data);
        exp_q.push_back(in_data);
      end
      if (in_wr && was_full) movf = 1;
      else if (in_clr_ovf)   movf = 0;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  logic [DATA_W-1:0] log_d[$];
  bit                log_l[$];

  // Per-cycle compare plus scoreboard of delivered beats.
  always @(negedge in_clk) begin
    if (in_rst_n) begin
      check("tvalid", m_tvalid, mv);
      if (mv) begin
        check("tdata", m_tdata, md);
        check("tlast", m_tlast, ml);
      end
      check("count", o_count, mq.size());
      check("full", o_full, mq.size() == DEPTH);
      check("overflow", o_overflow, movf);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) fail_now("sb_unexpected_beat");
        else check("sb_data", m_tdata, exp_q.pop_front());
        log_d.push_back(m_tdata);
        log_l.push_back(m_tlast);
      end
    end
  end

  task automatic log_data(input string name, input int idx, input logic [DATA_W-1:0] exp);
    if (idx < log_d.size()) check(name, log_d[idx], exp);
    else fail_now({name, "_missing"});
  endtask

  task automatic log_last(input string name, input int idx, input bit exp);
    if (idx < log_l.size()) check(name, log_l[idx], exp);
    else fail_now({name, "_missing"});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic write_word(input logic [DATA_W-1:0] d);
    in_wr   = 1'b1;
    in_data = d;
    tick();
    in_wr   = 1'b0;
  endtask

  task automatic apply_reset();
    in_wr      = 1'b0;
    in_clr_ovf = 1'b0;
    m_tready   = 1'b0;
    in_rst_n   = 1'b0;
    repeat (2) tick();
    in_rst_n   = 1'b1;
    log_d.delete();
    log_l.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    fail_now("watchdog_timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  bit rnd_done;
  int guard;

  initial begin
    // Reset and idle
    apply_reset();
    repeat (10) begin
      @(negedge in_clk);
      check("idle_tvalid", m_tvalid, 0);
      check("idle_count", o_count, 0);
      check("idle_full", o_full, 0);
      check("idle_ovf", o_overflow, 0);
    end
    tick();

    // Back-to-back stream, packets of 4
    apply_reset();
    in_pkt_len = 8'd4;
    m_tready   = 1'b1;
    fork
      for (int i = 1; i <= 8; i++) write_word(DATA_W'(i));
      begin
        @(negedge in_clk);
        @(negedge in_clk);
        check("lat_not_yet_valid", m_tvalid, 0);
        @(negedge in_clk);
        check("lat_first_valid", m_tvalid, 1);
        check("lat_first_data", m_tdata, 16'h0001);
      end
    join
    repeat (2) tick();
    check("b2b_beats", log_d.size(), 8);
    for (int i = 0; i < 8; i++) begin
      log_data("b2b_data", i, DATA_W'(i + 1));
      log_last("b2b_last", i, (i % 4) == 3);
    end

    // Backpressure, full, overflow and clear/drop collision
    apply_reset();
    in_pkt_len = 8'd4;
    m_tready   = 1'b0;
    for (int i = 1; i <= 10; i++) write_word(DATA_W'(i));
    @(negedge in_clk);
    check("bp_full", o_full, 1);
    check("bp_count", o_count, 8);
    check("bp_ovf", o_overflow, 1);
    check("bp_tvalid", m_tvalid, 1);
    check("bp_tdata", m_tdata, 16'h0001);
    repeat (3) begin
      tick();
      @(negedge in_clk);
      check("bp_stall_tdata", m_tdata, 16'h0001);
      check("bp_stall_tlast", m_tlast, 0);
    end
    tick();
    in_wr = 1'b1; in_data = 16'h0099; in_clr_ovf = 1'b1;
    tick();
    in_wr = 1'b0; in_clr_ovf = 1'b0;
    @(negedge in_clk);
    check("clr_vs_drop_ovf", o_overflow, 1);
    tick();
    in_clr_ovf = 1'b1;
    tick();
    in_clr_ovf = 1'b0;
    @(negedge in_clk);
    check("clr_ovf", o_overflow, 0);
    tick();
    m_tready = 1'b1;
    repeat (12) tick();
    check("bp_beats", log_d.size(), 9);
    for (int i = 0; i < 9; i++) begin
      log_data("bp_data", i, DATA_W'(i + 1));
      log_last("bp_last", i, (i % 4) == 3);
    end

    // Random backpressure, packets of 3
    apply_reset();
    in_pkt_len = 8'd3;
    rnd_done   = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 1)) tick();
          guard = 0;
          while (o_full && guard < 200) begin
            tick();
            guard++;
          end
          if (guard >= 200) fail_now("rnd_full_stuck");
          write_word(DATA_W'($urandom_range(0, 65535)));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          m_tready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    m_tready = 1'b1;
    guard = 0;
    while (log_d.size() < 200 && guard < 2000) begin
      tick();
      guard++;
    end
    check("rnd_beats", log_d.size(), 200);
    for (int i = 0; i < 200; i++) log_last("rnd_last", i, (i % 3) == 2);

    // Zero length means every beat is last
    apply_reset();
    in_pkt_len = 8'd0;
    m_tready   = 1'b1;
    for (int i = 1; i <= 4; i++) write_word(DATA_W'(16'h0100 + i));
    repeat (3) tick();
    check("len0_beats", log_d.size(), 4);
    for (int i = 0; i < 4; i++) log_last("len0_last", i, 1);

    // Length changed 2 -> 5 after the first beat was loaded
    apply_reset();
    in_pkt_len = 8'd2;
    m_tready   = 1'b1;
    write_word(16'h0201);
    write_word(16'h0202);
    in_pkt_len = 8'd5;
    for (int i = 3; i <= 7; i++) write_word(DATA_W'(16'h0200 + i));
    repeat (3) tick();
    check("lenchg_beats", log_d.size(), 7);
    for (int i = 0; i < 7; i++) log_last("lenchg_last", i, (i == 1) || (i == 6));

    // Asynchronous reset mid-packet
    apply_reset();
    in_pkt_len = 8'd4;
    m_tready   = 1'b1;
    for (int i = 1; i <= 3; i++) write_word(DATA_W'(16'h0300 + i));
    tick();
    @(negedge in_clk);
    check("pre_rst_tvalid", m_tvalid, 1);
    #2 in_rst_n = 1'b0;
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_count", o_count, 0);
    check("rst_full", o_full, 0);
    check("rst_ovf", o_overflow, 0);
    tick();
    in_rst_n = 1'b1;
    log_d.delete();
    log_l.delete();
    for (int i = 1; i <= 4; i++) write_word(DATA_W'(16'h0400 + i));
    repeat (3) tick();
    check("post_rst_beats", log_d.size(), 4);
    for (int i = 0; i < 4; i++) begin
      log_data("post_rst_data", i, DATA_W'(16'h0401 + i));
      log_last("post_rst_last", i, i == 3);
    end

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_st_tx.md
Name: axi4_st_tx

Overview:
- Parametrised AXI4-Stream transmitter: accepts words from a local write-strobe interface, buffers them in a DEPTH-entry synchronous FIFO and drives them onto an AXI4-Stream master port with full TVALID/TREADY backpressure.
- Generates TLAST from a programmable packet length.
- Flags overflow.
- Sits between a data producer and any AXI4-Stream sink in the streaming datapath.

Parameters:
- DATA_W, 16, data width in bits (TDATA width).
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- LEN_W, 8, width of the packet-length input.

Ports:
- in_clk  input  1  sole clock; all logic on the rising edge.
- in_rst_n  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  write data.
- in_wr  input  1  write strobe; a word is accepted when in_wr=1 and o_full=0.
- in_pkt_len  input  LEN_W  beats per packet; sampled at the first beat of each packet.
- o_full  output  1  FIFO full.
- o_count  output  $clog2(DEPTH)+1  FIFO occupancy; the output register is not counted.
- o_overflow  output  1  sticky; set when a write is dropped.
- in_clr_ovf  input  1  clears o_overflow.
- m_tdata  output  DATA_W  AXI4-Stream TDATA.
- m_tvalid  output  1  AXI4-Stream TVALID.
- m_tlast  output  1  AXI4-Stream TLAST.
- m_tready  input  1  AXI4-Stream TREADY from the sink.

Behaviour:
- Reset (in_rst_n=0, asynchronous): all outputs 0, pointers 0, beat counter 0, o_overflow 0. Reset mid-packet discards FIFO contents and the partial packet. After release, the first beat starts a new packet.
- FIFO: read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB distinguishes full from empty.
  - o_full = (occupancy == DEPTH).
  - Pointers wrap modulo 2*DEPTH.
- Write:
  - in_wr=1 and o_full=0: in_data is stored and occupancy increments at that edge.
  - in_wr=1 and o_full=1: the word is dropped and o_overflow is set at that edge. A simultaneous pop does not rescue the write; full is evaluated before the edge.
- o_overflow: in_clr_ovf=1 clears it. If clear and a new drop occur in the same cycle, the set wins.
- Output register: a single-entry register holds m_tdata, m_tvalid and m_tlast.
  - load = (FIFO not empty) and (m_tvalid=0 or m_tready=1).
  - On load, the FIFO head moves into the register, m_tvalid=1, and occupancy decrements.
  - m_tvalid=1 and m_tready=1 with no load: m_tvalid falls to 0.
  - Simultaneous push and load: occupancy unchanged.
- AXI rules:
  - While m_tvalid=1 and m_tready=0, m_tdata, m_tlast and m_tvalid hold stable.
  - m_tvalid never depends combinationally on m_tready.
  - All outputs are registered.
- Latency: a word written at edge k appears with m_tvalid=1 after edge k+1, provided the FIFO was empty and the register was free. There is no empty-FIFO bypass.
- Throughput: with m_tready held at 1 and one write per cycle, one beat per cycle is sustained.
- TLAST generation:
  - The beat counter (LEN_W bits) counts loaded beats.
  - On loading the first beat of a packet (counter=0), in_pkt_len is latched into len_q. in_pkt_len=0 is treated as 1.
  - m_tlast=1 on the beat loaded when counter == len_q-1; the counter then returns to 0. Otherwise the counter increments.
  - Changes to in_pkt_len mid-packet have no effect until the next packet.
- Empty FIFO with m_tready=1 after the last handshake: m_tvalid goes to 0 and m_tdata holds its last value.

Decomposition:
- Package axi4_st_pkg holds:
  - default width constants (DATA_W=16, DEPTH=8, LEN_W=8);
  - a function computing the pointer width from DEPTH;
  - a struct typedef {tdata, tlast} for the output register.
- Sub-module axi4_st_fifo_mem: DEPTH x DATA_W register-array storage with write port (we, waddr, wdata) and combinational read (raddr, rdata).
- Pointers, flags, output register and TLAST counter live in the top module.

Test Plan:
- Reset and idle: in_rst_n=0 then released, no writes -> m_tvalid=0, o_count=0, o_full=0, o_overflow=0 for 10 cycles.
- Back-to-back stream: in_pkt_len=4, write 0x0001..0x0008 on consecutive cycles, m_tready=1:
  - first m_tvalid one cycle after the first write;
  - 8 beats in order, one per cycle;
  - m_tlast on 0x0004 and 0x0008.
- Backpressure and full: m_tready=0, write 10 words (DEPTH=8):
  - register holds word 1, FIFO holds words 2-9, o_full=1, word 10 dropped, o_overflow=1;
  - m_tdata stays stable during stall;
  - raise m_tready -> words 1-9 delivered in order.
- Random m_tready toggling (50%) with 200 random words, in_pkt_len=3 -> scoreboard matches exactly, m_tlast on every 3rd beat, no beat changes while stalled.
- Corner cases:
  - in_pkt_len=0 -> m_tlast on every beat;
  - in_pkt_len changed 2->5 mid-packet -> current packet ends at 2 beats, next at 5;
  - in_clr_ovf and a drop in the same cycle -> o_overflow stays 1.
- Reset mid-packet: after 2 of 4 beats, pulse in_rst_n=0 asynchronously (between edges) -> outputs 0 immediately; after release, new writes start a fresh packet with m_tlast on its 4th beat.
